// File: rtl/rggen_apb_register_adapter_pkg.sv
// rggen_apb_register_adapter_pkg: register-bus access/status codes, adapter FSM states and a clog2 helper.
package rggen_apb_register_adapter_pkg;

    typedef enum logic [1:0] {
        RGGEN_READ  = 2'b10,
        RGGEN_WRITE = 2'b11
    } rggen_access_e;

    typedef enum logic [1:0] {
        RGGEN_OKAY   = 2'b00,
        RGGEN_EXOKAY = 2'b01,
        RGGEN_SLVERR = 2'b10,
        RGGEN_DECERR = 2'b11
    } rggen_status_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESPOND
    } adapter_state_e;

    function automatic int rggen_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/rggen_apb_register_adapter_if.sv
// rggen_apb_register_adapter_if: APB slave port and register-bus port of the adapter; names are from the adapter's point of view.
interface rggen_apb_register_adapter_if #(
    parameter int ADDRESS_WIDTH       = 8,
    parameter int LOCAL_ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH           = 32,
    parameter int REGISTERS           = 1
);
    logic                             i_psel;
    logic                             i_penable;
    logic [LOCAL_ADDRESS_WIDTH-1:0]   i_paddr;
    logic                             i_pwrite;
    logic [BUS_WIDTH/8-1:0]           i_pstrb;
    logic [BUS_WIDTH-1:0]             i_pwdata;
    logic                             o_pready;
    logic [BUS_WIDTH-1:0]             o_prdata;
    logic                             o_pslverr;
    logic                             o_register_valid;
    logic [1:0]                       o_register_access;
    logic [ADDRESS_WIDTH-1:0]         o_register_address;
    logic [BUS_WIDTH-1:0]             o_register_write_data;
    logic [BUS_WIDTH/8-1:0]           o_register_strobe;
    logic [REGISTERS-1:0]             i_register_active;
    logic [REGISTERS-1:0]             i_register_ready;
    logic [2*REGISTERS-1:0]           i_register_status;
    logic [BUS_WIDTH*REGISTERS-1:0]   i_register_read_data;

    modport slave (
        input  i_psel, i_penable, i_paddr, i_pwrite, i_pstrb, i_pwdata,
        input  i_register_active, i_register_ready, i_register_status, i_register_read_data,
        output o_pready, o_prdata, o_pslverr,
        output o_register_valid, o_register_access, o_register_address,
        output o_register_write_data, o_register_strobe
    );

    modport master (
        output i_psel, i_penable, i_paddr, i_pwrite, i_pstrb, i_pwdata,
        output i_register_active, i_register_ready, i_register_status, i_register_read_data,
        input  o_pready, o_prdata, o_pslverr,
        input  o_register_valid, o_register_access, o_register_address,
        input  o_register_write_data, o_register_strobe
    );
endinterface

// File: rtl/rggen_register_response_mux.sv
// rggen_register_response_mux: OR-merges active/ready/status/read_data replies of a register bank.
module rggen_register_response_mux #(
    parameter int REGISTERS = 1,
    parameter int BUS_WIDTH = 32
) (
    input  logic [REGISTERS-1:0]           i_active,
    input  logic [REGISTERS-1:0]           i_ready,
    input  logic [2*REGISTERS-1:0]         i_status,
    input  logic [BUS_WIDTH*REGISTERS-1:0] i_read_data,
    output logic                           o_any_active,
    output logic                           o_hit_ready,
    output logic [1:0]                     o_status,
    output logic [BUS_WIDTH-1:0]           o_read_data
);
    // Only active registers contribute; overlapping hits are merged without a check.
    always_comb begin
        o_any_active = |i_active;
        o_hit_ready  = |(i_active & i_ready);
        o_status     = '0;
        o_read_data  = '0;
        for (int i = 0; i < REGISTERS; i++) begin
            o_status    |= i_active[i] ? i_status[2*i+:2] : 2'b00;
            o_read_data |= i_active[i] ? i_read_data[BUS_WIDTH*i+:BUS_WIDTH] : '0;
        end
    end
endmodule

// File: rtl/rggen_apb_register_adapter.sv
// rggen_apb_register_adapter: APB slave issuing one register-bus access at a time and returning the merged reply.
// Optional: define RGGEN_APB_ADAPTER_TIMEOUT_EN to end a BUSY access after TIMEOUT_CYCLES with SLVERR.
module rggen_apb_register_adapter
    import rggen_apb_register_adapter_pkg::*;
#(
    parameter int ADDRESS_WIDTH       = 8,
    parameter int LOCAL_ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH           = 32,
    parameter int REGISTERS           = 1,
    parameter bit ERROR_STATUS        = 1'b0
`ifdef RGGEN_APB_ADAPTER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES      = 256
`endif
) (
    input logic                         i_clk,
    input logic                         i_rst_n,
    rggen_apb_register_adapter_if.slave bus
);
    localparam int STRB_WIDTH = BUS_WIDTH / 8;
    localparam int WORD_BITS  = rggen_clog2(STRB_WIDTH);
    localparam logic [ADDRESS_WIDTH-1:0] ADDRESS_MASK = ~ADDRESS_WIDTH'((1 << WORD_BITS) - 1);

    logic [LOCAL_ADDRESS_WIDTH-1:0] paddr;
    logic                           any_active;
    logic                           hit_ready;
    logic                           timeout;
    logic [1:0]                     merged_status;
    logic [1:0]                     resp_status;
    logic [BUS_WIDTH-1:0]           merged_data;
    logic [BUS_WIDTH-1:0]           resp_data;
    adapter_state_e                 state_q, state_d;
    logic                           valid_q, valid_d;
    logic [1:0]                     access_q, access_d;
    logic [ADDRESS_WIDTH-1:0]       address_q, address_d;
    logic [BUS_WIDTH-1:0]           write_data_q, write_data_d;
    logic [STRB_WIDTH-1:0]          strobe_q, strobe_d;
    logic                           pready_q, pready_d;
    logic [BUS_WIDTH-1:0]           prdata_q, prdata_d;
    logic                           pslverr_q, pslverr_d;

    assign paddr = bus.i_paddr;

    rggen_register_response_mux #(
        .REGISTERS (REGISTERS),
        .BUS_WIDTH (BUS_WIDTH)
    ) u_response_mux (
        .i_active     (bus.i_register_active),
        .i_ready      (bus.i_register_ready),
        .i_status     (bus.i_register_status),
        .i_read_data  (bus.i_register_read_data),
        .o_any_active (any_active),
        .o_hit_ready  (hit_ready),
        .o_status     (merged_status),
        .o_read_data  (merged_data)
    );

`ifdef RGGEN_APB_ADAPTER_TIMEOUT_EN
    localparam int COUNT_WIDTH = (TIMEOUT_CYCLES > 1) ? rggen_clog2(TIMEOUT_CYCLES) : 1;

    logic [COUNT_WIDTH-1:0] count_q, count_d;

    assign timeout = count_q == COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

    // Count BUSY cycles; held at zero outside BUSY so every access starts fresh.
    always_comb count_d = (state_q == ST_BUSY) ? count_q + 1'b1 : '0;

    // Timeout counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) count_q <= '0;
        else          count_q <= count_d;
    end
`else
    assign timeout = 1'b0;
`endif

    // Next-state and registered-output logic for the IDLE -> BUSY -> RESPOND handshake.
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        access_d     = access_q;
        address_d    = address_q;
        write_data_d = write_data_q;
        strobe_d     = strobe_q;
        pready_d     = 1'b0;
        prdata_d     = '0;
        pslverr_d    = 1'b0;
        resp_status  = hit_ready ? merged_status : any_active ? RGGEN_SLVERR : RGGEN_DECERR;
        resp_data    = hit_ready ? merged_data : '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_psel && !bus.i_penable) begin
                    state_d      = ST_BUSY;
                    valid_d      = 1'b1;
                    access_d     = bus.i_pwrite ? RGGEN_WRITE : RGGEN_READ;
                    address_d    = ADDRESS_WIDTH'(paddr) & ADDRESS_MASK;
                    write_data_d = bus.i_pwrite ? bus.i_pwdata : '0;
                    strobe_d     = bus.i_pwrite ? bus.i_pstrb : '1;
                end
            end
            ST_BUSY: begin
                if (hit_ready || !any_active || timeout) begin
                    state_d   = ST_RESPOND;
                    valid_d   = 1'b0;
                    pready_d  = 1'b1;
                    prdata_d  = (access_q == RGGEN_WRITE) ? '0 : resp_data;
                    pslverr_d = resp_status[1] && (ERROR_STATUS || resp_status != RGGEN_DECERR);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset returns to IDLE with every output low.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            valid_q      <= 1'b0;
            access_q     <= '0;
            address_q    <= '0;
            write_data_q <= '0;
            strobe_q     <= '0;
            pready_q     <= 1'b0;
            prdata_q     <= '0;
            pslverr_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            access_q     <= access_d;
            address_q    <= address_d;
            write_data_q <= write_data_d;
            strobe_q     <= strobe_d;
            pready_q     <= pready_d;
            prdata_q     <= prdata_d;
            pslverr_q    <= pslverr_d;
        end
    end

    assign bus.o_pready              = pready_q;
    assign bus.o_prdata              = prdata_q;
    assign bus.o_pslverr             = pslverr_q;
    assign bus.o_register_valid      = valid_q;
    assign bus.o_register_access     = access_q;
    assign bus.o_register_address    = address_q;
    assign bus.o_register_write_data = write_data_q;
    assign bus.o_register_strobe     = strobe_q;
endmodule

// File: tb/tb_rggen_apb_register_adapter.sv
// tb_rggen_apb_register_adapter: drives APB transfers into two adapters (ERROR_STATUS 1 and 0) sharing one modelled register bank.
module tb_rggen_apb_register_adapter;
    localparam int AW = 8;
    localparam int LAW = 8;
    localparam int BW = 32;
    localparam int NR = 3;
`ifdef RGGEN_APB_ADAPTER_TIMEOUT_EN
    localparam int TO = 4;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rggen_apb_register_adapter_if #(.ADDRESS_WIDTH(AW), .LOCAL_ADDRESS_WIDTH(LAW), .BUS_WIDTH(BW), .REGISTERS(NR)) bus ();
    rggen_apb_register_adapter_if #(.ADDRESS_WIDTH(AW), .LOCAL_ADDRESS_WIDTH(LAW), .BUS_WIDTH(BW), .REGISTERS(NR)) bus_ok ();

    rggen_apb_register_adapter #(
        .ADDRESS_WIDTH(AW), .LOCAL_ADDRESS_WIDTH(LAW), .BUS_WIDTH(BW), .REGISTERS(NR), .ERROR_STATUS(1'b1)
`ifdef RGGEN_APB_ADAPTER_TIMEOUT_EN
        , .TIMEOUT_CYCLES(TO)
`endif
    ) u_dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    rggen_apb_register_adapter #(
        .ADDRESS_WIDTH(AW), .LOCAL_ADDRESS_WIDTH(LAW), .BUS_WIDTH(BW), .REGISTERS(NR), .ERROR_STATUS(1'b0)
`ifdef RGGEN_APB_ADAPTER_TIMEOUT_EN
        , .TIMEOUT_CYCLES(TO)
`endif
    ) u_dut_ok (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_ok));

    assign bus_ok.i_psel               = bus.i_psel;
    assign bus_ok.i_penable            = bus.i_penable;
    assign bus_ok.i_paddr              = bus.i_paddr;
    assign bus_ok.i_pwrite             = bus.i_pwrite;
    assign bus_ok.i_pstrb              = bus.i_pstrb;
    assign bus_ok.i_pwdata             = bus.i_pwdata;
    assign bus_ok.i_register_active    = bus.i_register_active;
    assign bus_ok.i_register_ready     = bus.i_register_ready;
    assign bus_ok.i_register_status    = bus.i_register_status;
    assign bus_ok.i_register_read_data = bus.i_register_read_data;

    // Register bank model: the plan says who answers, after how many waiting cycles, with what.
    logic [NR-1:0]    plan_active = '0;
    logic [NR-1:0]    plan_ready = '0;
    logic [2*NR-1:0]  plan_status = '0;
    logic [BW*NR-1:0] plan_data = '0;
    int               plan_wait = 0;
    int               wait_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_cnt <= 0;
        else        wait_cnt <= bus.o_register_valid ? wait_cnt + 1 : 0;
    end

    always_comb begin
        bus.i_register_active    = bus.o_register_valid ? plan_active : '0;
        bus.i_register_ready     = (bus.o_register_valid && wait_cnt >= plan_wait) ? (plan_active & plan_ready) : '0;
        bus.i_register_status    = plan_status;
        bus.i_register_read_data = '0;
        for (int i = 0; i < NR; i++)
            if (bus.o_register_valid && plan_active[i]) bus.i_register_read_data[BW*i+:BW] = plan_data[BW*i+:BW];
    end

    // Observations of one transfer.
    int              obs_lat;
    logic            obs_valid, obs_err, obs_err_ok, obs_rdy_ok;
    logic [AW-1:0]   obs_addr;
    logic [1:0]      obs_access;
    logic [BW/8-1:0] obs_strobe;
    logic [BW-1:0]   obs_wdata, obs_rdata;

    // Expected response, from the plan: latency in cycles after setup, read data and error flags.
    int              e_lat;
    logic [BW-1:0]   e_data;
    logic            e_err, e_err_ok;

    function automatic void model(input logic wr, output int lat, output logic [BW-1:0] data, output logic err, output logic err_ok);
        logic [1:0]    st;
        logic [BW-1:0] d;
        st = 2'b00;
        d  = '0;
        lat = 2;
        if (plan_active == '0) st = 2'b11;
        else begin
            lat = plan_wait + 2;
            for (int i = 0; i < NR; i++)
                if (plan_active[i]) begin
                    st |= plan_status[2*i+:2];
                    d  |= plan_data[BW*i+:BW];
                end
`ifdef RGGEN_APB_ADAPTER_TIMEOUT_EN
            if ((plan_active & plan_ready) == '0 || plan_wait >= TO) begin
                lat = TO + 1;
                st  = 2'b10;
                d   = '0;
            end
`endif
        end
        data   = wr ? '0 : d;
        err    = st[1];
        err_ok = st[1] && st != 2'b11;
    endfunction

    // One APB transfer: setup, access, wait for pready (bounded); records what was seen.
    task automatic run_xfer(input logic [LAW-1:0] addr, input logic wr, input logic [BW/8-1:0] strb, input logic [BW-1:0] wdata);
        @(negedge clk);
        bus.i_psel    = 1'b1;
        bus.i_penable = 1'b0;
        bus.i_paddr   = addr;
        bus.i_pwrite  = wr;
        bus.i_pstrb   = strb;
        bus.i_pwdata  = wdata;
        @(negedge clk);
        bus.i_penable = 1'b1;
        obs_valid  = bus.o_register_valid;
        obs_addr   = bus.o_register_address;
        obs_access = bus.o_register_access;
        obs_strobe = bus.o_register_strobe;
        obs_wdata  = bus.o_register_write_data;
        obs_lat    = -1;
        for (int c = 1; c <= 40; c++) begin
            if (bus.o_pready) begin
                obs_lat    = c;
                obs_rdata  = bus.o_prdata;
                obs_err    = bus.o_pslverr;
                obs_rdy_ok = bus_ok.o_pready;
                obs_err_ok = bus_ok.o_pslverr;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        checks++; if (bus.o_pready !== 1'b0) begin failures++; $display("FAIL reset pready got=%b exp=0", bus.o_pready); end
        checks++; if (bus.o_prdata !== '0) begin failures++; $display("FAIL reset prdata got=%h exp=0", bus.o_prdata); end
        checks++; if (bus.o_pslverr !== 1'b0) begin failures++; $display("FAIL reset pslverr got=%b exp=0", bus.o_pslverr); end
        checks++; if (bus.o_register_valid !== 1'b0) begin failures++; $display("FAIL reset valid got=%b exp=0", bus.o_register_valid); end
        checks++; if (bus.o_register_access !== 2'b00) begin failures++; $display("FAIL reset access got=%b exp=00", bus.o_register_access); end
        checks++; if (bus.o_register_address !== '0) begin failures++; $display("FAIL reset address got=%h exp=0", bus.o_register_address); end
        checks++; if (bus.o_register_write_data !== '0) begin failures++; $display("FAIL reset write_data got=%h exp=0", bus.o_register_write_data); end
        checks++; if (bus.o_register_strobe !== '0) begin failures++; $display("FAIL reset strobe got=%h exp=0", bus.o_register_strobe); end
    endtask

    task automatic test_read_hit();
        plan_active = 3'b001; plan_ready = 3'b001; plan_wait = 0; plan_status = '0;
        plan_data = {32'h0, 32'h0, 32'hDEADBEEF};
        run_xfer(8'h04, 1'b0, 4'hF, 32'h0);
        checks++; if (obs_lat !== 2) begin failures++; $display("FAIL read_hit latency got=%0d exp=2", obs_lat); end
        checks++; if (obs_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL read_hit prdata got=%h exp=deadbeef", obs_rdata); end
        checks++; if (obs_err !== 1'b0) begin failures++; $display("FAIL read_hit pslverr got=%b exp=0", obs_err); end
        checks++; if (obs_access !== 2'b10) begin failures++; $display("FAIL read_hit access got=%b exp=10", obs_access); end
        checks++; if (obs_strobe !== 4'hF || obs_wdata !== '0) begin failures++; $display("FAIL read_hit strobe/wdata got=%h/%h exp=f/0", obs_strobe, obs_wdata); end
    endtask

    task automatic test_write_wait();
        plan_active = 3'b010; plan_ready = 3'b010; plan_wait = 3; plan_status = '0;
        plan_data = {32'h0, 32'hAAAA5555, 32'h0};
        run_xfer(8'h07, 1'b1, 4'b0011, 32'h12345678);
        checks++; if (obs_addr !== 8'h04) begin failures++; $display("FAIL write address got=%h exp=04", obs_addr); end
        checks++; if (obs_access !== 2'b11) begin failures++; $display("FAIL write access got=%b exp=11", obs_access); end
        checks++; if (obs_strobe !== 4'b0011) begin failures++; $display("FAIL write strobe got=%b exp=0011", obs_strobe); end
        checks++; if (obs_wdata !== 32'h12345678) begin failures++; $display("FAIL write write_data got=%h exp=12345678", obs_wdata); end
        checks++; if (obs_lat !== 5) begin failures++; $display("FAIL write latency got=%0d exp=5", obs_lat); end
        checks++; if (obs_rdata !== '0) begin failures++; $display("FAIL write prdata got=%h exp=0", obs_rdata); end
    endtask

    task automatic test_unmapped();
        plan_active = '0; plan_ready = '0; plan_wait = 0; plan_status = '1; plan_data = '1;
        run_xfer(8'h10, 1'b0, 4'hF, 32'h0);
        checks++; if (obs_lat !== 2) begin failures++; $display("FAIL unmapped latency got=%0d exp=2", obs_lat); end
        checks++; if (obs_rdata !== '0) begin failures++; $display("FAIL unmapped prdata got=%h exp=0", obs_rdata); end
        checks++; if (obs_err !== 1'b1) begin failures++; $display("FAIL unmapped pslverr(err_status=1) got=%b exp=1", obs_err); end
        checks++; if (obs_err_ok !== 1'b0) begin failures++; $display("FAIL unmapped pslverr(err_status=0) got=%b exp=0", obs_err_ok); end
    endtask

    task automatic test_slverr();
        plan_active = 3'b100; plan_ready = 3'b100; plan_wait = 1; plan_status = 6'b10_00_00;
        plan_data = {32'h00000001, 32'h0, 32'h0};
        run_xfer(8'h08, 1'b0, 4'hF, 32'h0);
        checks++; if (obs_lat !== 3) begin failures++; $display("FAIL slverr latency got=%0d exp=3", obs_lat); end
        checks++; if (obs_err !== 1'b1 || obs_err_ok !== 1'b1) begin failures++; $display("FAIL slverr pslverr got=%b/%b exp=1/1", obs_err, obs_err_ok); end
        checks++; if (obs_rdata !== 32'h1) begin failures++; $display("FAIL slverr prdata got=%h exp=1", obs_rdata); end
    endtask

    task automatic test_random();
        logic [LAW-1:0]  a;
        logic            w;
        logic [BW/8-1:0] s;
        logic [BW-1:0]   d;
        for (int n = 0; n < 30; n++) begin
            plan_active = NR'($urandom_range(0, 7));
            plan_ready  = NR'($urandom) & plan_active;
            if (plan_ready == '0) plan_ready = plan_active;
            plan_wait   = $urandom_range(0, 4);
            plan_status = (2*NR)'($urandom);
            plan_data   = {$urandom, $urandom, $urandom};
            a = LAW'($urandom); w = 1'($urandom); s = (BW/8)'($urandom); d = $urandom;
            model(w, e_lat, e_data, e_err, e_err_ok);
            run_xfer(a, w, s, d);
            checks++; if (obs_valid !== 1'b1) begin failures++; $display("FAIL rand[%0d] valid got=%b exp=1", n, obs_valid); end
            checks++; if (obs_addr !== (a & 8'hFC)) begin failures++; $display("FAIL rand[%0d] address got=%h exp=%h", n, obs_addr, a & 8'hFC); end
            checks++; if (obs_access !== (w ? 2'b11 : 2'b10)) begin failures++; $display("FAIL rand[%0d] access got=%b wr=%b", n, obs_access, w); end
            checks++; if (obs_strobe !== (w ? s : 4'hF)) begin failures++; $display("FAIL rand[%0d] strobe got=%h exp=%h", n, obs_strobe, w ? s : 4'hF); end
            checks++; if (obs_wdata !== (w ? d : 32'h0)) begin failures++; $display("FAIL rand[%0d] write_data got=%h exp=%h", n, obs_wdata, w ? d : 32'h0); end
            checks++; if (obs_lat !== e_lat) begin failures++; $display("FAIL rand[%0d] latency got=%0d exp=%0d", n, obs_lat, e_lat); end
            checks++; if (obs_rdata !== e_data) begin failures++; $display("FAIL rand[%0d] prdata got=%h exp=%h", n, obs_rdata, e_data); end
            checks++; if (obs_err !== e_err) begin failures++; $display("FAIL rand[%0d] pslverr got=%b exp=%b", n, obs_err, e_err); end
            checks++; if (obs_err_ok !== e_err_ok) begin failures++; $display("FAIL rand[%0d] pslverr_ok got=%b exp=%b", n, obs_err_ok, e_err_ok); end
            checks++; if (obs_rdy_ok !== 1'b1) begin failures++; $display("FAIL rand[%0d] pready_ok got=%b exp=1", n, obs_rdy_ok); end
        end
    endtask

    task automatic test_reset_busy();
        plan_active = 3'b001; plan_ready = 3'b001; plan_wait = 30; plan_status = '0; plan_data = '0;
        @(negedge clk);
        bus.i_psel = 1'b1; bus.i_penable = 1'b0; bus.i_paddr = 8'h0C; bus.i_pwrite = 1'b0;
        @(negedge clk);
        bus.i_penable = 1'b1;
        @(negedge clk);
        checks++; if (bus.o_register_valid !== 1'b1) begin failures++; $display("FAIL rst_busy valid_before got=%b exp=1", bus.o_register_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.o_register_valid !== 1'b0) begin failures++; $display("FAIL rst_busy valid got=%b exp=0", bus.o_register_valid); end
        checks++; if (bus.o_pready !== 1'b0 || bus_ok.o_pready !== 1'b0) begin failures++; $display("FAIL rst_busy pready got=%b exp=0", bus.o_pready); end
        checks++; if (bus.o_register_access !== 2'b00) begin failures++; $display("FAIL rst_busy access got=%b exp=00", bus.o_register_access); end
        @(negedge clk);
        bus.i_psel = 1'b0; bus.i_penable = 1'b0;
        rst_n = 1'b1;
        plan_wait = 0; plan_data = {32'h0, 32'h0, 32'hCAFEF00D};
        run_xfer(8'h0C, 1'b0, 4'hF, 32'h0);
        checks++; if (obs_lat !== 2) begin failures++; $display("FAIL rst_busy next latency got=%0d exp=2", obs_lat); end
        checks++; if (obs_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL rst_busy next prdata got=%h exp=cafef00d", obs_rdata); end
    endtask

`ifdef RGGEN_APB_ADAPTER_TIMEOUT_EN
    task automatic test_timeout();
        plan_active = 3'b001; plan_ready = 3'b000; plan_wait = 0; plan_status = '0; plan_data = {32'h0, 32'h0, 32'h55AA55AA};
        run_xfer(8'h00, 1'b0, 4'hF, 32'h0);
        checks++; if (obs_lat !== TO + 1) begin failures++; $display("FAIL timeout latency got=%0d exp=%0d", obs_lat, TO + 1); end
        checks++; if (obs_err !== 1'b1 || obs_err_ok !== 1'b1) begin failures++; $display("FAIL timeout pslverr got=%b/%b exp=1/1", obs_err, obs_err_ok); end
        checks++; if (obs_rdata !== '0) begin failures++; $display("FAIL timeout prdata got=%h exp=0", obs_rdata); end
        plan_ready = 3'b001; plan_wait = TO - 1;
        run_xfer(8'h00, 1'b0, 4'hF, 32'h0);
        checks++; if (obs_lat !== TO + 1) begin failures++; $display("FAIL timeout_race latency got=%0d exp=%0d", obs_lat, TO + 1); end
        checks++; if (obs_err !== 1'b0 || obs_rdata !== 32'h55AA55AA) begin failures++; $display("FAIL timeout_race resp got=%b/%h exp=0/55aa55aa", obs_err, obs_rdata); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bus.i_psel = 1'b0; bus.i_penable = 1'b0; bus.i_paddr = '0;
        bus.i_pwrite = 1'b0; bus.i_pstrb = '0; bus.i_pwdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_read_hit();
        test_write_wait();
        test_unmapped();
        test_slverr();
        test_random();
        test_reset_busy();
`ifdef RGGEN_APB_ADAPTER_TIMEOUT_EN
        test_timeout();
`endif
        @(negedge clk);
        bus.i_psel = 1'b0; bus.i_penable = 1'b0;
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
